// File: rtl/vote_pkg.sv
// Shared types and constants for the vote result reporter: FSM states,
// candidate index type, packet header and packet lengths.
package vote_pkg;

    localparam logic [7:0] HEADER       = 8'hA5;
    localparam int         PKT_LEN_BASE = 5;
    localparam int         PKT_LEN_CSUM = 6;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        CMP,
        SEND
    } state_t;

    typedef logic [1:0] cand_idx_t;

endpackage

// File: rtl/vote_result_reporter_if.sv
// Request, tally and result signals between the vote logger side and the
// reporter; the reporter takes the slave modport.
interface vote_result_reporter_if;
    import vote_pkg::*;

    logic       mode;
    logic       start;
    logic [7:0] cand1_votes;
    logic [7:0] cand2_votes;
    logic [7:0] cand3_votes;
    logic [7:0] cand4_votes;
    logic       busy;
    logic       tx;
    cand_idx_t  winner;
    logic       winner_valid;
    logic       tie;

    modport master (
        output mode, start, cand1_votes, cand2_votes, cand3_votes, cand4_votes,
        input  busy, tx, winner, winner_valid, tie
    );

    modport slave (
        input  mode, start, cand1_votes, cand2_votes, cand3_votes, cand4_votes,
        output busy, tx, winner, winner_valid, tie
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. ready is high when idle and during the final cycle of
// the stop bit, so a load then starts the next frame with no idle gap.
module uart_tx_byte #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    logic        active;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [8:0]  shift;
    logic        stop_done;

    assign stop_done = active && (bit_cnt == 4'd9) && (baud_cnt == BAUD_LAST);
    assign ready     = !active || stop_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active   <= 1'b0;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (load && ready) begin
            active   <= 1'b1;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (active) begin
            if (baud_cnt == BAUD_LAST) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    tx      <= shift[0];
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

    // Data bits then the stop bit shift out LSB first behind the start bit.
    always_ff @(posedge clock) begin
        if (load && ready) begin
            shift <= {1'b1, data};
        end else if (active && (baud_cnt == BAUD_LAST) && (bit_cnt != 4'd9)) begin
            shift <= {1'b1, shift[8:1]};
        end
    end

endmodule

// File: rtl/vote_result_reporter.sv
// Snapshots the four tallies, finds leader/tie and streams A5 + tallies over 8N1.
// Optional VOTE_REPORT_CHECKSUM_EN appends an XOR checksum byte.
module vote_result_reporter
    import vote_pkg::*;
#(
    parameter int BAUD_DIV = 868,
    parameter int CNT_W    = 8
) (
    input logic                   clock,
    input logic                   reset,
    vote_result_reporter_if.slave bus
);

`ifdef VOTE_REPORT_CHECKSUM_EN
    localparam int PKT_LEN = PKT_LEN_CSUM;
`else
    localparam int PKT_LEN = PKT_LEN_BASE;
`endif
    localparam logic [2:0] LAST_BYTE = 3'(PKT_LEN - 1);

    state_t           state;
    logic [1:0]       cmp_cnt;
    logic [2:0]       byte_idx;
    logic             busy;
    cand_idx_t        winner;
    logic             winner_valid;
    logic             tie;

    logic [CNT_W-1:0] snap [4];
    logic [CNT_W-1:0] max_val;
    cand_idx_t        max_idx;
    logic             run_tie;

    cand_idx_t        cand_idx;
    logic [CNT_W-1:0] cand_val;
    logic [CNT_W-1:0] nxt_max;
    cand_idx_t        nxt_idx;
    logic             nxt_tie;

    logic [2:0]       next_idx;
    logic [7:0]       next_byte;
    logic             uart_load;
    logic             uart_ready;
    logic [7:0]       uart_data;

    assign cand_idx = cmp_cnt + 2'd1;
    assign cand_val = snap[cand_idx];

    // Equal keeps the lower index and flags a tie; strictly greater clears it.
    always_comb begin
        nxt_max = max_val;
        nxt_idx = max_idx;
        nxt_tie = run_tie;
        if (cand_val > max_val) begin
            nxt_max = cand_val;
            nxt_idx = cand_idx;
            nxt_tie = 1'b0;
        end else if (cand_val == max_val) begin
            nxt_tie = 1'b1;
        end
    end

    assign next_idx = byte_idx + 3'd1;

    always_comb begin
        case (next_idx)
            3'd1:    next_byte = 8'(snap[0]);
            3'd2:    next_byte = 8'(snap[1]);
            3'd3:    next_byte = 8'(snap[2]);
            3'd4:    next_byte = 8'(snap[3]);
`ifdef VOTE_REPORT_CHECKSUM_EN
            3'd5:    next_byte = HEADER ^ 8'(snap[0]) ^ 8'(snap[1]) ^ 8'(snap[2]) ^ 8'(snap[3]);
`endif
            default: next_byte = HEADER;
        endcase
    end

    // Header is loaded on CMP exit so its start bit begins as results appear.
    assign uart_load = ((state == CMP) && (cmp_cnt == 2'd2)) ||
                       ((state == SEND) && uart_ready && (byte_idx != LAST_BYTE));
    assign uart_data = (state == CMP) ? HEADER : next_byte;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
            tie          <= 1'b0;
            cmp_cnt      <= '0;
            byte_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && bus.mode) begin
                        state <= SNAP;
                        busy  <= 1'b1;
                    end
                end
                SNAP: begin
                    state   <= CMP;
                    cmp_cnt <= '0;
                end
                CMP: begin
                    cmp_cnt <= cmp_cnt + 2'd1;
                    if (cmp_cnt == 2'd2) begin
                        state        <= SEND;
                        byte_idx     <= '0;
                        winner       <= nxt_idx;
                        tie          <= nxt_tie;
                        winner_valid <= (nxt_max != '0);
                    end
                end
                SEND: begin
                    if (uart_ready) begin
                        if (byte_idx == LAST_BYTE) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            byte_idx <= next_idx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Snapshot and running max; candidate 1 seeds the compare.
    always_ff @(posedge clock) begin
        if (state == SNAP) begin
            snap[0] <= bus.cand1_votes;
            snap[1] <= bus.cand2_votes;
            snap[2] <= bus.cand3_votes;
            snap[3] <= bus.cand4_votes;
            max_val <= bus.cand1_votes;
            max_idx <= '0;
            run_tie <= 1'b0;
        end else if (state == CMP) begin
            max_val <= nxt_max;
            max_idx <= nxt_idx;
            run_tie <= nxt_tie;
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clock (clock),
        .reset (reset),
        .load  (uart_load),
        .data  (uart_data),
        .ready (uart_ready),
        .tx    (bus.tx)
    );

    assign bus.busy         = busy;
    assign bus.winner       = winner;
    assign bus.winner_valid = winner_valid;
    assign bus.tie          = tie;

endmodule

// File: tb/tb_vote_result_reporter.sv
// Bench for vote_result_reporter at BAUD_DIV=4: reference model of leader/tie
// and packet contents, serial decode of tx, timing of busy and results.
module tb_vote_result_reporter;
    import vote_pkg::*;

    localparam int B = 4;
`ifdef VOTE_REPORT_CHECKSUM_EN
    localparam int L = 6;
`else
    localparam int L = 5;
`endif
    localparam int PKT_CYC = 10 * L * B;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    vote_result_reporter_if bus();

    vote_result_reporter #(
        .BAUD_DIV (B),
        .CNT_W    (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Runs one report from the current negedge; ends at the negedge busy first reads 0.
    task automatic do_report(input string name,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d,
                             input int mutate_at, input logic [7:0] mutate_val,
                             input int restart_at, input bit drop_mode);
        logic [7:0] v [4];
        logic [7:0] exp_pkt [6];
        logic [7:0] got [6];
        logic [1:0] exp_w;
        logic       exp_wv;
        logic       exp_t;
        int         mx;
        int         cnt;
        int         frame_err;
        int         rel;
        int         bitpos;
        int         j;
        int         k;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        mx = 0;
        for (int i = 0; i < 4; i++) if (int'(v[i]) > mx) mx = int'(v[i]);
        cnt   = 0;
        exp_w = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (int'(v[i]) == mx) begin
                cnt++;
                exp_w = 2'(i);
            end
        end
        exp_wv = (mx != 0);
        exp_t  = (cnt >= 2);
        exp_pkt[0] = 8'hA5;
        for (int i = 1; i <= 4; i++) exp_pkt[i] = v[i-1];
        exp_pkt[5] = 8'hA5 ^ a ^ b ^ c ^ d;
        for (int i = 0; i < 6; i++) got[i] = 8'h00;
        frame_err = 0;

        bus.mode        = 1'b1;
        bus.cand1_votes = a;
        bus.cand2_votes = b;
        bus.cand3_votes = c;
        bus.cand4_votes = d;
        bus.start       = 1'b1;
        for (int cy = 1; cy <= 5 + PKT_CYC; cy++) begin
            @(negedge clock);
            if (cy == 1) begin
                bus.start = 1'b0;
                tests++;
                if (bus.busy !== 1'b1) begin
                    fails++;
                    $display("FAIL %s busy_after_start: got %b want 1", name, bus.busy);
                end
            end
            if (cy == mutate_at) bus.cand2_votes = mutate_val;
            if (cy == restart_at) bus.start = 1'b1;
            if (cy == restart_at + 1) bus.start = 1'b0;
            if (drop_mode && cy == 8) bus.mode = 1'b0;
            if (cy == 4) begin
                tests++;
                if (bus.tx !== 1'b1) begin
                    fails++;
                    $display("FAIL %s tx_idle_before_header: got %b want 1", name, bus.tx);
                end
            end
            if (cy == 5) begin
                tests++;
                if (bus.tx !== 1'b0) begin
                    fails++;
                    $display("FAIL %s header_start_bit: got %b want 0", name, bus.tx);
                end
                tests++;
                if (bus.winner !== exp_w) begin
                    fails++;
                    $display("FAIL %s winner: got %0d want %0d", name, bus.winner, exp_w);
                end
                tests++;
                if (bus.winner_valid !== exp_wv) begin
                    fails++;
                    $display("FAIL %s winner_valid: got %b want %b", name, bus.winner_valid, exp_wv);
                end
                tests++;
                if (bus.tie !== exp_t) begin
                    fails++;
                    $display("FAIL %s tie: got %b want %b", name, bus.tie, exp_t);
                end
            end
            rel = cy - 5;
            if (rel >= 0 && rel < PKT_CYC && (rel % B) == B / 2) begin
                bitpos = rel / B;
                j = bitpos / 10;
                k = bitpos % 10;
                if (k == 0) begin
                    if (bus.tx !== 1'b0) frame_err++;
                end else if (k == 9) begin
                    if (bus.tx !== 1'b1) frame_err++;
                end else begin
                    got[j][k-1] = bus.tx;
                end
            end
            if (cy == 4 + PKT_CYC) begin
                tests++;
                if (bus.busy !== 1'b1) begin
                    fails++;
                    $display("FAIL %s busy_last_stop_cycle: got %b want 1", name, bus.busy);
                end
            end
            if (cy == 5 + PKT_CYC) begin
                tests++;
                if (bus.busy !== 1'b0) begin
                    fails++;
                    $display("FAIL %s busy_fall: got %b want 0", name, bus.busy);
                end
            end
        end
        for (int i = 0; i < L; i++) begin
            tests++;
            if (got[i] !== exp_pkt[i]) begin
                fails++;
                $display("FAIL %s byte%0d: got %02h want %02h", name, i, got[i], exp_pkt[i]);
            end
        end
        tests++;
        if (frame_err != 0) begin
            fails++;
            $display("FAIL %s framing: got %0d bad start/stop bits want 0", name, frame_err);
        end
        bus.mode = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        bus.mode        = 1'b1;
        bus.start       = 1'b1;
        bus.cand1_votes = 8'd1;
        bus.cand2_votes = 8'd2;
        bus.cand3_votes = 8'd3;
        bus.cand4_votes = 8'd4;
        reset           = 1'b0;
        repeat (3) @(negedge clock);
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++;
        if (bus.tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
        tests++;
        if (bus.winner !== 2'd0) begin fails++; $display("FAIL reset_winner: got %0d want 0", bus.winner); end
        tests++;
        if (bus.winner_valid !== 1'b0) begin fails++; $display("FAIL reset_winner_valid: got %b want 0", bus.winner_valid); end
        tests++;
        if (bus.tie !== 1'b0) begin fails++; $display("FAIL reset_tie: got %b want 0", bus.tie); end
        bus.start = 1'b0;
        reset     = 1'b1;
        bad       = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.busy !== 1'b0 || bus.tx !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL start_during_reset: got %0d busy cycles want 0", bad); end
    endtask

    task automatic test_mode_zero();
        int bad;
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clock);
            if (bus.busy !== 1'b0 || bus.tx !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL mode_zero_ignored: got %0d active cycles want 0", bad); end
        bus.mode = 1'b1;
    endtask

    task automatic test_busy_restart();
        int bad;
        do_report("busy_restart", 8'd1, 8'd8, 8'd3, 8'd5, 0, 8'd0, 30, 1'b0);
        bad = 0;
        repeat (3 * PKT_CYC / 2) begin
            @(negedge clock);
            if (bus.busy !== 1'b0 || bus.tx !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL single_packet: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_reset_mid_frame();
        bus.mode        = 1'b1;
        bus.cand1_votes = 8'd1;
        bus.cand2_votes = 8'd2;
        bus.cand3_votes = 8'd3;
        bus.cand4_votes = 8'd4;
        bus.start       = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4 + 21 * B) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        tests++;
        if (bus.tx !== 1'b1) begin fails++; $display("FAIL midframe_reset_tx: got %b want 1", bus.tx); end
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL midframe_reset_busy: got %b want 0", bus.busy); end
        tests++;
        if (bus.winner_valid !== 1'b0) begin fails++; $display("FAIL midframe_reset_valid: got %b want 0", bus.winner_valid); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        do_report("after_reset", 8'd6, 8'd2, 8'd6, 8'd1, 0, 8'd0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] r [4];
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 4; i++)
                r[i] = (n < 2) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            do_report($sformatf("random%0d", n), r[0], r[1], r[2], r[3], 0, 8'd0, 0, 1'b0);
        end
    endtask

    initial begin
        bus.mode        = 1'b0;
        bus.start       = 1'b0;
        bus.cand1_votes = 8'd0;
        bus.cand2_votes = 8'd0;
        bus.cand3_votes = 8'd0;
        bus.cand4_votes = 8'd0;
        test_reset();
        do_report("tie_report", 8'd3, 8'd7, 8'd7, 8'd2, 0, 8'd0, 0, 1'b0);
        do_report("clear_winner", 8'd9, 8'd4, 8'd0, 8'd12, 0, 8'd0, 0, 1'b0);
        do_report("all_zero", 8'd0, 8'd0, 8'd0, 8'd0, 0, 8'd0, 0, 1'b0);
        test_mode_zero();
        test_busy_restart();
        do_report("snapshot", 8'd1, 8'd5, 8'd2, 8'd3, 30, 8'd6, 0, 1'b0);
        do_report("mode_fall", 8'd4, 8'd4, 8'd9, 8'd9, 0, 8'd0, 0, 1'b1);
        do_report("back_to_back_a", 8'd2, 8'd0, 8'd2, 8'd1, 0, 8'd0, 0, 1'b0);
        do_report("back_to_back_b", 8'd0, 8'd0, 8'd0, 8'd255, 0, 8'd0, 0, 1'b0);
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vote_result_reporter.md
# vote_result_reporter

Downstream consumer of the voting machine's four per-candidate 8-bit tallies. On a report request in result mode it snapshots the tallies, determines the leading candidate and tie status, and streams a framed result packet over a UART-style 8N1 serial line for an external display or logger. It runs alongside the LED result path and never feeds back into tally logic.

## Interface
- BAUD_DIV, 868: clock cycles per serial bit, legal range 2..65535.
- CNT_W, 8: tally width; fixed at 8 for this packet format.
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low; 0 resets all state immediately.
- mode  in  1  1 = result mode; 0 = voting mode.
- start  in  1  one-cycle report request.
- cand1_votes..cand4_votes  in  8 each  live tallies from the vote logger.
- busy  out  1  high from the cycle after an accepted start until the last stop bit ends.
- tx  out  1  serial output; idles high.
- winner  out  2  index of the leading candidate, 0..3 = candidates 1..4.
- winner_valid  out  1  high when the maximum tally is nonzero.
- tie  out  1  high when two or more candidates share the maximum.

## Operation
- Reset values: busy=0, tx=1, winner=0, winner_valid=0, tie=0, FSM=IDLE.
- start is accepted only in IDLE with mode=1. It is ignored when busy, when mode=0, or when asserted with reset active.
- States and transitions:
  - IDLE -> SNAP on an accepted start.
  - SNAP latches all four tallies into snapshot registers. Later tally changes do not affect the report.
  - SNAP -> CMP.
  - CMP takes 3 cycles. It runs a sequential compare of candidates 2, 3 and 4 against the running max, which is seeded with candidate 1.
  - A strictly greater value replaces the max and clears the running tie flag. An equal value sets the tie flag; the lower index is kept.
  - CMP -> SEND. winner, winner_valid and tie are registered on CMP exit and hold until the next report or reset.
  - SEND transmits bytes in order: 0xA5 header, then cand1, cand2, cand3, cand4 snapshots.
  - SEND -> IDLE after the final byte's stop bit.
- All-zero tallies: winner=0, winner_valid=0, tie=1.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BAUD_DIV cycles. There are no idle gaps between bytes.
- mode falling mid-report does not abort; the packet completes.
- reset asserted mid-frame: tx returns to 1 asynchronously and the partial packet is dropped.

## Timing
- start sampled high at edge T -> SNAP at T+1, busy=1 from T+1.
- CMP occupies T+2..T+4. Result outputs are valid from T+5.
- Header start bit is driven from T+5.
- Packet length is 50·BAUD_DIV cycles, or 60·BAUD_DIV with checksum.
- busy falls one cycle after the final stop bit period ends. A start in that same cycle is accepted.

## Configuration
- VOTE_REPORT_CHECKSUM_EN:
  - Defined: a sixth byte is appended, equal to the XOR of the header and the four tally bytes.
  - Undefined: the packet is 5 bytes and no checksum logic is present.

## Structure
- Shared package vote_pkg holds:
  - the header constant 0xA5;
  - the FSM state enum (IDLE, SNAP, CMP, SEND);
  - the 2-bit candidate index typedef;
  - the packet length constants (5 and 6).
- One sub-module, uart_tx_byte:
  - contains the baud counter, bit counter and shift register;
  - load/ready handshake: load is accepted when ready=1, and ready rises in the cycle the stop bit completes.
- The top level handles the FSM, snapshot, compare and byte sequencing.

## Test plan
All cases use BAUD_DIV=4.
- Normal report with tie: tallies 3,7,7,2, mode=1, one start pulse -> winner=1, tie=1, winner_valid=1 at T+5. tx decodes A5 03 07 07 02, plus A4 with the checksum macro. busy low after 200 cycles, or 240 with checksum.
- Clear winner: tallies 9,4,0,12 -> winner=3, tie=0, winner_valid=1.
- All zero: tallies 0,0,0,0 -> winner_valid=0, tie=1. The packet is still sent.
- Ignored requests:
  - start with mode=0 -> busy stays 0 and tx stays 1.
  - second start while busy -> only one packet is sent.
- Snapshot isolation: change cand2 from 5 to 6 during SEND -> the transmitted cand2 byte is 05.
- Reset mid-frame: assert reset during the third byte -> tx=1 and busy=0 immediately. After release, a new start yields a complete, correct packet.
